uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 18 +
 rtl/uart_rx_fifo_byte_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding and
// default line parameters for the 25 MHz core clock.
package uart_rx_fifo_pkg;

   localparam int unsigned DEFAULT_CLK_FREQ = 25_000_000;
   localparam int unsigned DEFAULT_BAUD     = 115_200;

   // IDLE waits for a falling edge, START re-checks it at mid-bit, DATA
   // collects eight bits, STOP checks framing, BREAK waits out a held-low line.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// byte_fifo: small synchronous circular buffer. Pointers carry one extra wrap
// bit so that full and empty are distinguishable without a separate counter.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module byte_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

   // Storage and pointer update; push and pop may both happen in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver. The pin is synchronized, frames are decoded
// by a mid-bit sampling FSM, and good bytes are queued in byte_fifo behind a
// valid/ready handshake. Framing errors and overruns are reported as one-cycle
// pulses.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD       = DEFAULT_BAUD,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int unsigned DIV  = CLK_FREQ / BAUD;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV);

   localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);

   logic [1:0]    r_sync;
   logic          w_rxs;

   rx_state_t     r_state;
   rx_state_t     w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_nx;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nx;

   logic          w_stop_good;
   logic          w_stop_bad;
   logic          r_frame_err;
   logic          r_overrun;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic [7:0]    w_head;

   assign w_rxs        = r_sync[1];
   assign w_pop        = rx_ready && !w_empty;
   assign rx_valid     = !w_empty;
   assign rx_data      = w_head;
   assign rx_frame_err = r_frame_err;
   assign rx_overrun   = r_overrun;

   // Two-flop synchronizer for the asynchronous pin; idles high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[0], uart_rxd};
      end
   end

   // Receiver state, bit timing counter, bit index, shift register and the
   // registered one-cycle error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_idx       <= w_idx_nx;
         r_shift     <= w_shift_nx;
         r_frame_err <= w_stop_bad;
         r_overrun   <= w_stop_good && w_full && !w_pop;
      end
   end

   // Next-state logic: start bit checked at mid-bit, then every bit one full
   // bit period later, so each sample lands in the middle of its bit cell.
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_idx_nx    = r_idx;
      w_shift_nx  = r_shift;
      w_stop_good = 1'b0;
      w_stop_bad  = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state_nx = START;
               w_cnt_nx   = '0;
            end
         end

         START: begin
            if (r_cnt == C_HALF_LAST) begin
               w_cnt_nx   = '0;
               w_idx_nx   = '0;
               // A line that is high again at mid-bit was only a glitch.
               w_state_nx = w_rxs ? IDLE : DATA;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end

         DATA: begin
            if (r_cnt == C_DIV_LAST) begin
               w_cnt_nx   = '0;
               w_shift_nx = {w_rxs, r_shift[7:1]};
               w_idx_nx   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nx = STOP;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end

         STOP: begin
            if (r_cnt == C_DIV_LAST) begin
               w_cnt_nx = '0;
               if (w_rxs) begin
                  w_stop_good = 1'b1;
                  w_state_nx  = IDLE;
               end else begin
                  w_stop_bad  = 1'b1;
                  w_state_nx  = BREAK;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end

         BREAK: begin
            // Held-low line: wait for the idle level so only one error is seen.
            if (w_rxs) begin
               w_state_nx = IDLE;
            end
         end

         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_stop_good),
      .i_din   (r_shift),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A frame-level reference model predicts
// FIFO contents and error pulses from the sampling instants derived from the
// bit-timing rules; DUT outputs are compared every cycle on the falling edge.
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQ = 25_000_000;
   localparam int unsigned BAUD     = 115_200;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned DIV      = CLK_FREQ / BAUD;
   localparam int unsigned HALF     = DIV / 2;
   localparam int unsigned NO_ABORT = 0;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;

   always #20 clk = ~clk;

   uart_rx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rxd     (uart_rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Reference model state: expected FIFO contents and frames in flight.
   logic [7:0]  mdl_q[$];
   int unsigned pend_edge[$];
   logic [7:0]  pend_byte[$];
   bit          pend_good[$];
   bit          exp_ferr  = 1'b0;
   bit          exp_ovr   = 1'b0;
   bit          mon_en    = 1'b0;
   int unsigned n_dut_pop = 0;
   int unsigned n_mdl_pop = 0;

   always @(negedge clk) begin : monitor
      bit pop;
      if (mon_en) begin
         chk("valid", 32'(rx_valid), 32'(mdl_q.size() > 0));
         if (mdl_q.size() > 0) chk("data", 32'(rx_data), 32'(mdl_q[0]));
         chk("frame_err", 32'(rx_frame_err), 32'(exp_ferr));
         chk("overrun", 32'(rx_overrun), 32'(exp_ovr));
         exp_ferr = 1'b0;
         exp_ovr  = 1'b0;
         if (rst) begin
            mdl_q.delete();
            pend_edge.delete();
            pend_byte.delete();
            pend_good.delete();
         end else begin
            if (rx_valid && rx_ready) n_dut_pop++;
            pop = (mdl_q.size() > 0) && rx_ready;
            if (pop) begin
               void'(mdl_q.pop_front());
               n_mdl_pop++;
            end
            if (pend_edge.size() > 0 && pend_edge[0] == cyc + 1) begin
               if (pend_good[0]) begin
                  if (mdl_q.size() < DEPTH) mdl_q.push_back(pend_byte[0]);
                  else exp_ovr = 1'b1;
               end else begin
                  exp_ferr = 1'b1;
               end
               void'(pend_edge.pop_front());
               void'(pend_byte.pop_front());
               void'(pend_good.pop_front());
            end
         end
      end
   end

   // Background consumer with a per-mille acceptance probability.
   bit          rand_rdy = 1'b0;
   int unsigned rdy_pm   = 0;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         rx_ready = ($urandom_range(0, 999) < rdy_pm);
      end
   end

   // Drive one frame: start, 8 data bits LSB first, stop held for stop_len
   // cycles. The line goes low right after edge P; the synchronizer makes the
   // FSM see it at T0 = P+3, so the stop sample is at T0+HALF+9*DIV.
   task automatic send_frame(input logic [7:0] b, input bit stop_val,
                             input int unsigned stop_len, input bit rdy_at_stop,
                             input int unsigned abort_at);
      logic [9:0]  bits;
      logic [3:0]  bi;
      int unsigned stop_edge;
      bits      = {stop_val, b, 1'b0};
      stop_edge = 0;
      for (int unsigned j = 0; j < 9 * DIV + stop_len; j++) begin
         @(posedge clk);
         #1;
         if (abort_at != NO_ABORT && j == abort_at) begin
            rst = 1'b1;
            return;
         end
         bi       = (j / DIV > 9) ? 4'd9 : 4'(j / DIV);
         uart_rxd = bits[bi];
         if (j == 0) begin
            stop_edge = cyc + 3 + HALF + 9 * DIV;
            pend_edge.push_back(stop_edge);
            pend_byte.push_back(b);
            pend_good.push_back(stop_val);
         end
         if (rdy_at_stop) rx_ready = (cyc + 1 == stop_edge);
      end
   endtask

   task automatic hold_line(input logic val, input int unsigned n);
      for (int unsigned j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
         uart_rxd = val;
      end
   endtask

   task automatic set_ready(input logic val);
      @(posedge clk);
      #1;
      rx_ready = val;
   endtask

   initial begin
      logic [7:0]  b;
      bit          good;
      int unsigned slen;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      chk("rst_frame_err", 32'(rx_frame_err), 32'd0);
      chk("rst_overrun", 32'(rx_overrun), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single byte, consumer always ready.
      rx_ready = 1'b1;
      send_frame(8'h55, 1'b1, DIV, 1'b0, NO_ABORT);
      hold_line(1'b1, 20);

      // Short low glitch must be rejected at the start-bit check.
      hold_line(1'b0, 50);
      hold_line(1'b1, 300);

      // Bad stop bit followed by a long break, then a good frame.
      send_frame(8'hA3, 1'b0, DIV, 1'b0, NO_ABORT);
      hold_line(1'b0, 3000);
      hold_line(1'b1, 20);
      send_frame(8'h3C, 1'b1, DIV, 1'b0, NO_ABORT);
      hold_line(1'b1, 10);

      // Overrun on the fifth byte, then drain.
      set_ready(1'b0);
      for (int unsigned k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, DIV, 1'b0, NO_ABORT);
      hold_line(1'b1, 5);
      set_ready(1'b1);
      hold_line(1'b1, 10);

      // Full FIFO with a pop coinciding with the stop sample: no overrun.
      set_ready(1'b0);
      for (int unsigned k = 0; k < DEPTH; k++) send_frame(8'($urandom), 1'b1, DIV, 1'b0, NO_ABORT);
      send_frame(8'h77, 1'b1, DIV, 1'b1, NO_ABORT);
      hold_line(1'b1, 5);
      set_ready(1'b1);
      hold_line(1'b1, 10);

      // Reset during data bit 4 with a byte already buffered.
      set_ready(1'b0);
      send_frame(8'h5A, 1'b1, DIV, 1'b0, NO_ABORT);
      send_frame(8'($urandom), 1'b1, DIV, 1'b0, 5 * DIV + 100);
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid", 32'(rx_valid), 32'd0);
      chk("abort_data", 32'(rx_data), 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      uart_rxd = 1'b1;
      rx_ready = 1'b1;
      hold_line(1'b1, 20);
      send_frame(8'hC8, 1'b1, DIV, 1'b0, NO_ABORT);
      hold_line(1'b1, 10);

      // Randomized frames: random consumer pressure, occasional bad stop bits,
      // and stop bits trimmed so the next start edge follows the stop sample.
      rand_rdy = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0:       rdy_pm = 0;
            1:       rdy_pm = 2;
            default: rdy_pm = 500;
         endcase
         b    = 8'($urandom);
         good = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 2))
            0:       slen = HALF + 1;
            1:       slen = DIV;
            default: slen = DIV + $urandom_range(0, 40);
         endcase
         if (!good) slen = DIV;
         send_frame(b, good, slen, 1'b0, NO_ABORT);
         if (!good) hold_line(1'b1, 20);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      set_ready(1'b1);
      hold_line(1'b1, 20);

      @(negedge clk);
      chk("end_valid", 32'(rx_valid), 32'd0);
      chk("pop_count", n_dut_pop, n_mdl_pop);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
